// File: rtl/pwm_fade_ctrl.sv
// Breathing-profile threshold sequencer for an N-bit PWM; updates land on PWM period boundaries.
// Define PWM_FADE_ONESHOT_EN to stop in IDLE after one profile instead of looping.
module pwm_fade_ctrl #(
  parameter int unsigned THRESHOLD_NBITS  = 8,
  parameter int unsigned PERIODS_PER_STEP = 4,
  parameter int unsigned STEP             = 1,
  parameter int unsigned HOLD_STEPS       = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [THRESHOLD_NBITS-1:0] min_level,
  input  logic [THRESHOLD_NBITS-1:0] max_level,
  output logic [THRESHOLD_NBITS-1:0] threshold,
  output logic                       period_tick,
  output logic [2:0]                 phase,
  output logic                       cycle_done
);

  localparam int unsigned N      = THRESHOLD_NBITS;
  localparam int unsigned SCNT_W = (PERIODS_PER_STEP > 1) ? $clog2(PERIODS_PER_STEP) : 1;
  localparam int unsigned HOLD_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  localparam int unsigned EXT_W  = N + 2;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] RAMP_UP   = 3'd1;
  localparam logic [2:0] HOLD_HIGH = 3'd2;
  localparam logic [2:0] RAMP_DOWN = 3'd3;
  localparam logic [2:0] HOLD_LOW  = 3'd4;

  logic [N-1:0]      pcnt_q, pcnt_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [N-1:0]      thr_q, thr_d;
  logic [2:0]        phase_q, phase_d;
  logic              tick_q, tick_d;
  logic              done_q, done_d;

  logic                    step_tick_c;
  logic                    hold_last_c;
  logic                    bounds_ok_c;
  logic                    start_ok_c;
  logic [EXT_W-1:0]        up_sum_c;
  logic signed [EXT_W-1:0] dn_diff_c;
  logic                    up_hit_c;
  logic                    dn_hit_c;

`ifdef PWM_FADE_ONESHOT_EN
  logic armed_q, armed_d;
  assign start_ok_c = armed_q;
`else
  assign start_ok_c = 1'b1;
`endif

  // Arithmetic is widened so the step can never wrap past either rail.
  always_comb begin
    step_tick_c = tick_q && (scnt_q == SCNT_W'(PERIODS_PER_STEP - 1));
    hold_last_c = (hold_q == HOLD_W'(HOLD_STEPS - 1));
    bounds_ok_c = (max_level > min_level);
    up_sum_c    = EXT_W'(thr_q) + EXT_W'(STEP);
    dn_diff_c   = $signed(EXT_W'(thr_q)) - $signed(EXT_W'(STEP));
    up_hit_c    = (up_sum_c >= EXT_W'(max_level));
    dn_hit_c    = (dn_diff_c <= $signed(EXT_W'(min_level)));
  end

  always_comb begin
    pcnt_d  = pcnt_q + 1'b1;
    tick_d  = (pcnt_d == {N{1'b1}});
    scnt_d  = scnt_q;
    hold_d  = hold_q;
    thr_d   = thr_q;
    phase_d = phase_q;
    done_d  = 1'b0;
`ifdef PWM_FADE_ONESHOT_EN
    armed_d = armed_q;
    if (tick_q && !en) armed_d = 1'b1;
`endif

    if (phase_q == IDLE) begin
      scnt_d = '0;
    end else if (tick_q) begin
      scnt_d = step_tick_c ? '0 : SCNT_W'(scnt_q + 1'b1);
    end

    if (tick_q) begin
      if (phase_q == IDLE) begin
        thr_d = min_level;
        if (en && bounds_ok_c && start_ok_c) phase_d = RAMP_UP;
      end else if (!en || !bounds_ok_c) begin
        phase_d = IDLE;
        thr_d   = min_level;
      end else if (step_tick_c) begin
        case (phase_q)
          RAMP_UP: begin
            if (up_hit_c) begin
              thr_d   = max_level;
              phase_d = HOLD_HIGH;
              hold_d  = '0;
            end else begin
              thr_d = N'(up_sum_c);
            end
          end
          HOLD_HIGH: begin
            if (hold_last_c) phase_d = RAMP_DOWN;
            else             hold_d  = HOLD_W'(hold_q + 1'b1);
          end
          RAMP_DOWN: begin
            if (dn_hit_c) begin
              thr_d   = min_level;
              phase_d = HOLD_LOW;
              hold_d  = '0;
            end else begin
              thr_d = N'(dn_diff_c);
            end
          end
          HOLD_LOW: begin
            if (hold_last_c) begin
              done_d = 1'b1;
`ifdef PWM_FADE_ONESHOT_EN
              phase_d = IDLE;
              armed_d = 1'b0;
`else
              phase_d = RAMP_UP;
`endif
            end else begin
              hold_d = HOLD_W'(hold_q + 1'b1);
            end
          end
          default: phase_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q  <= '0;
      scnt_q  <= '0;
      hold_q  <= '0;
      thr_q   <= '0;
      phase_q <= IDLE;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef PWM_FADE_ONESHOT_EN
      armed_q <= 1'b1;
`endif
    end else begin
      pcnt_q  <= pcnt_d;
      scnt_q  <= scnt_d;
      hold_q  <= hold_d;
      thr_q   <= thr_d;
      phase_q <= phase_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
`ifdef PWM_FADE_ONESHOT_EN
      armed_q <= armed_d;
`endif
    end
  end

  assign threshold   = thr_q;
  assign period_tick = tick_q;
  assign phase       = phase_q;
  assign cycle_done  = done_q;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Bench for pwm_fade_ctrl: two instances (STEP=1 and STEP=3) checked each cycle against a period-level model.
module tb_pwm_fade_ctrl;

  localparam int PMAX = 15;
  localparam int PPS  = 2;
  localparam int HOLD = 2;
`ifdef PWM_FADE_ONESHOT_EN
  localparam bit ONESHOT = 1'b1;
`else
  localparam bit ONESHOT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en_s   [2];
  logic [3:0] min_s  [2];
  logic [3:0] max_s  [2];
  logic [3:0] thr_o  [2];
  logic       tick_o [2];
  logic [2:0] ph_o   [2];
  logic       done_o [2];

  int checks = 0;
  int errors = 0;
  int kcnt   = 0;

  always #5 clk = ~clk;

  pwm_fade_ctrl #(.THRESHOLD_NBITS(4), .PERIODS_PER_STEP(2), .STEP(1), .HOLD_STEPS(2)) dut (
    .clk(clk), .rst(rst), .en(en_s[0]), .min_level(min_s[0]), .max_level(max_s[0]),
    .threshold(thr_o[0]), .period_tick(tick_o[0]), .phase(ph_o[0]), .cycle_done(done_o[0]));

  pwm_fade_ctrl #(.THRESHOLD_NBITS(4), .PERIODS_PER_STEP(2), .STEP(3), .HOLD_STEPS(2)) dut3 (
    .clk(clk), .rst(rst), .en(en_s[1]), .min_level(min_s[1]), .max_level(max_s[1]),
    .threshold(thr_o[1]), .period_tick(tick_o[1]), .phase(ph_o[1]), .cycle_done(done_o[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0d want %0d", name, $time, act, exp);
    end
  endtask

  // Model state: what each instance should show after the current edge.
  int m_pcnt[2], m_thr[2], m_ph[2], m_done[2], m_tick[2], m_run[2], m_held[2], m_armed[2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_pcnt[i] = 0; m_thr[i] = 0; m_ph[i] = 0; m_done[i] = 0;
        m_tick[i] = 0; m_run[i] = 0; m_held[i] = 0; m_armed[i] = 1;
      end else begin
        int lo, hi, st;
        bit tk;
        lo = int'(min_s[i]);
        hi = int'(max_s[i]);
        st = (i == 0) ? 1 : 3;
        tk = (m_pcnt[i] == PMAX);
        m_done[i] = 0;
        if (tk) begin
          if (!en_s[i]) m_armed[i] = 1;
          if (m_ph[i] == 0) begin
            m_thr[i] = lo;
            m_run[i] = 0;
            if (en_s[i] && hi > lo && (!ONESHOT || m_armed[i] != 0)) m_ph[i] = 1;
          end else if (!en_s[i] || hi <= lo) begin
            m_ph[i]  = 0;
            m_thr[i] = lo;
          end else begin
            m_run[i]++;
            if (m_run[i] % PPS == 0) begin
              if (m_ph[i] == 1) begin
                if (m_thr[i] + st >= hi) begin m_thr[i] = hi; m_ph[i] = 2; m_held[i] = 0; end
                else m_thr[i] = m_thr[i] + st;
              end else if (m_ph[i] == 2) begin
                m_held[i]++;
                if (m_held[i] == HOLD) m_ph[i] = 3;
              end else if (m_ph[i] == 3) begin
                if (m_thr[i] - st <= lo) begin m_thr[i] = lo; m_ph[i] = 4; m_held[i] = 0; end
                else m_thr[i] = m_thr[i] - st;
              end else begin
                m_held[i]++;
                if (m_held[i] == HOLD) begin
                  m_done[i] = 1;
                  m_ph[i]   = ONESHOT ? 0 : 1;
                  if (ONESHOT) m_armed[i] = 0;
                end
              end
            end
          end
        end
        m_pcnt[i] = (m_pcnt[i] + 1) % (PMAX + 1);
        m_tick[i] = (m_pcnt[i] == PMAX) ? 1 : 0;
      end
    end
  end

  always @(posedge clk) begin
    if (rst) kcnt <= 0;
    else     kcnt <= kcnt + 1;
  end

  // Per-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("model_thr[%0d]", i),  32'(thr_o[i]),  32'(m_thr[i]));
      chk($sformatf("model_phase[%0d]", i), 32'(ph_o[i]),  32'(m_ph[i]));
      chk($sformatf("model_done[%0d]", i), 32'(done_o[i]), 32'(m_done[i]));
      chk($sformatf("model_tick[%0d]", i), 32'(tick_o[i]), 32'(m_tick[i]));
    end
  end

  task automatic at_edge(input int n);
    while (kcnt < n) begin
      @(posedge clk);
      #1;
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    en_s[0] = 1'b1; min_s[0] = 4'd2; max_s[0] = 4'd6;
    en_s[1] = 1'b1; min_s[1] = 4'd1; max_s[1] = 4'd15;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_thr",   32'(thr_o[0]),  32'd0);
    chk("rst_phase", 32'(ph_o[0]),   32'd0);
    chk("rst_done",  32'(done_o[0]), 32'd0);
    chk("rst_tick",  32'(tick_o[0]), 32'd0);

    at_edge(14);  chk("tick_early", 32'(tick_o[0]), 32'd0);
    at_edge(15);  chk("tick_first", 32'(tick_o[0]), 32'd1);
    at_edge(16);  chk("start_thr", 32'(thr_o[0]), 32'd2);
                  chk("start_phase", 32'(ph_o[0]), 32'd1);
    at_edge(47);  chk("up_pre3", 32'(thr_o[0]), 32'd2);
    at_edge(48);  chk("up_3", 32'(thr_o[0]), 32'd3);
    at_edge(80);  chk("up_4", 32'(thr_o[0]), 32'd4);
    at_edge(144); chk("up_6", 32'(thr_o[0]), 32'd6);
                  chk("hold_high", 32'(ph_o[0]), 32'd2);
    at_edge(176); chk("sat_15", 32'(thr_o[1]), 32'd15);
                  chk("sat_phase", 32'(ph_o[1]), 32'd2);
    at_edge(207); chk("hold_high_end", 32'(ph_o[0]), 32'd2);
    at_edge(208); chk("ramp_down", 32'(ph_o[0]), 32'd3);
    at_edge(272); chk("down_4", 32'(thr_o[0]), 32'd4);
                  chk("sat_down12", 32'(thr_o[1]), 32'd12);
    at_edge(336); chk("low_thr", 32'(thr_o[0]), 32'd2);
                  chk("low_phase", 32'(ph_o[0]), 32'd4);
    at_edge(368); chk("sat_down3", 32'(thr_o[1]), 32'd3);
    at_edge(399); chk("done_pre", 32'(done_o[0]), 32'd0);
    at_edge(400); chk("done_pulse", 32'(done_o[0]), 32'd1);
                  chk("loop_phase", 32'(ph_o[0]), ONESHOT ? 32'd0 : 32'd1);
                  chk("sat_low1", 32'(thr_o[1]), 32'd1);
    at_edge(401); chk("done_off", 32'(done_o[0]), 32'd0);
    at_edge(464); chk("loop_thr4", 32'(thr_o[0]), ONESHOT ? 32'd2 : 32'd4);
    at_edge(470); en_s[0] = 1'b0;
    at_edge(480); chk("drop_phase", 32'(ph_o[0]), 32'd0);
                  chk("drop_thr", 32'(thr_o[0]), 32'd2);
    at_edge(485); en_s[0] = 1'b1; min_s[0] = 4'd7; max_s[0] = 4'd7;
    at_edge(496); chk("degen_thr", 32'(thr_o[0]), 32'd7);
    at_edge(528); chk("degen_phase", 32'(ph_o[0]), 32'd0);
                  chk("degen_thr2", 32'(thr_o[0]), 32'd7);
    at_edge(530); min_s[0] = 4'd2; max_s[0] = 4'd6;
    at_edge(544); chk("restart_phase", 32'(ph_o[0]), 32'd1);
                  chk("restart_thr", 32'(thr_o[0]), 32'd2);
    at_edge(600); chk("pre_rst_thr", 32'(thr_o[0]), 32'd3);
    rst = 1'b1;
    @(posedge clk);
    #2;
    chk("midrst_thr",   32'(thr_o[0]),  32'd0);
    chk("midrst_phase", 32'(ph_o[0]),   32'd0);
    chk("midrst_tick",  32'(tick_o[0]), 32'd0);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_fade_ctrl.md
# pwm_fade_ctrl

Duty-cycle sequencer placed directly upstream of the N-bit PWM generator. It drives the PWM `threshold` input with a triangular "breathing" profile: ramp up, hold, ramp down, hold, repeat. All threshold updates are aligned to PWM period boundaries, so the PWM never sees a mid-period duty change. It tracks the PWM period with an internal free-running counter of the same width, which is reset together with the PWM.

## Interface

**Parameters**
- `THRESHOLD_NBITS`, default 8: width of the threshold and of the period counter. PWM period is 2^N clocks.
- `PERIODS_PER_STEP`, default 4: number of PWM periods between threshold updates (≥1).
- `STEP`, default 1: threshold increment or decrement per update (≥1).
- `HOLD_STEPS`, default 16: number of update slots spent in each hold state (≥1).

**Ports**
- `clk`, input, 1: clock, 100 MHz.
- `rst`, input, 1: reset. One clock; reset is synchronous and active-high.
- `en`, input, 1: run enable.
- `min_level`, input, N: lower threshold bound.
- `max_level`, input, N: upper threshold bound.
- `threshold`, output, N: registered value that drives the PWM `threshold` input.
- `period_tick`, output, 1: one-clock pulse while the period counter equals all-ones.
- `phase`, output, 3: current state. IDLE=0, RAMP_UP=1, HOLD_HIGH=2, RAMP_DOWN=3, HOLD_LOW=4.
- `cycle_done`, output, 1: one-clock pulse when HOLD_LOW completes.

## Operation

- **Period counter `pcnt`:** N bits, increments every clock, wraps 2^N−1 → 0. `period_tick` = (pcnt == all-ones).
- **Step counter `scnt`:**
  - Counts `period_tick`s from 0 to PERIODS_PER_STEP−1.
  - `step_tick` = `period_tick` && (scnt == PERIODS_PER_STEP−1).
  - Cleared while in IDLE.
- **Hold counter:** counts `step_tick`s in the hold states up to HOLD_STEPS−1. Cleared on entry to each hold state.
- **FSM transitions:**
  - **IDLE:** on each `period_tick`, threshold ← min_level. If `en` && (max_level > min_level) at a `period_tick` → RAMP_UP.
  - **RAMP_UP:** on `step_tick`, compute t = threshold + STEP in N+1 bits.
    - If t ≥ max_level: threshold ← max_level and go to HOLD_HIGH.
    - Else: threshold ← t.
  - **HOLD_HIGH:** after HOLD_STEPS `step_tick`s → RAMP_DOWN.
  - **RAMP_DOWN:** compute t = threshold − STEP in N+1 bits, signed.
    - If t ≤ min_level: threshold ← min_level and go to HOLD_LOW.
    - Else: threshold ← t.
  - **HOLD_LOW:** after HOLD_STEPS `step_tick`s, pulse `cycle_done` → RAMP_UP.
- **Enable drop:** `en` = 0 in any non-IDLE state → IDLE at the next `period_tick`, with threshold ← min_level on that same edge.
- **Bounds changed mid-run:** comparisons always use the live values. If threshold exceeds a lowered max_level during RAMP_UP, the next `step_tick` clamps it to max_level. The same rule applies to min_level during RAMP_DOWN.
- **Degenerate bounds:** max_level ≤ min_level holds the block in IDLE. If this occurs in a non-IDLE state, the block returns to IDLE at the next `period_tick`.

## Timing

- **Reset values:** pcnt=0, scnt=0, hold counter=0, threshold=0, `phase`=IDLE, `period_tick`=0, `cycle_done`=0.
- **First tick:** the first `period_tick` occurs 2^N−1 clocks after the first non-reset edge.
- **Update alignment:** threshold and `phase` update only on the edge that ends a `period_tick` cycle. The new value is therefore visible when pcnt==0, i.e. the first cycle of a new PWM period.
- **`cycle_done`:** asserted in the cycle where pcnt==0 after the final HOLD_LOW `step_tick`.
- **Start latency:** `en` sampled high at a `period_tick` → RAMP_UP. The first increment occurs PERIODS_PER_STEP periods later.
- **Reset mid-operation:** all registers return to reset values on the next edge. No partial update is permitted.

## Configuration

- **`PWM_FADE_ONESHOT_EN` defined:**
  - HOLD_LOW completion pulses `cycle_done` and goes to IDLE instead of RAMP_UP.
  - Restart requires `en` to be sampled low at ≥1 `period_tick`, then high at a later `period_tick`.
- **Not defined:** the profile loops indefinitely while `en`=1, and `cycle_done` pulses once per loop.

## Test plan

All scenarios use THRESHOLD_NBITS=4 (16-clock period), PERIODS_PER_STEP=2 and HOLD_STEPS=2 unless noted.

- **Reset:** hold `rst` high for 5 clocks, then release.
  - Required: threshold=0, `phase`=0, `cycle_done`=0.
  - Required: first `period_tick` on the 15th clock after release.
- **Ramp up:** min=2, max=6, en=1 with STEP=1.
  - Required: threshold=2 from the first period, then 3, 4, 5, 6 at 32-clock intervals.
  - Required: every change is first visible with pcnt==0.
  - Required: `phase`=2 after the value 6 is reached.
- **Full loop, macro off:** continue the ramp-up scenario.
  - Required: 64 clocks at 6, then 5, 4, 3, 2, then 64 clocks in HOLD_LOW.
  - Required: one `cycle_done` pulse, then `phase`=1 again.
- **Saturation:** STEP=3, min=1, max=15.
  - Required: ramp sequence 1, 4, 7, 10, 13, 15, with no wrap to 0.
  - Required: ramp down 12, 9, 6, 3, 1.
- **Enable and degenerate bounds:** drop `en` while threshold=4 in RAMP_UP.
  - Required: `phase`=0 and threshold=2 at the next pcnt==0.
  - Then set min=7, max=7 with en=1: the block stays in IDLE with threshold=7.
- **`PWM_FADE_ONESHOT_EN` defined:** after the first `cycle_done`, `phase` stays 0 while en=1.
  - en low for one period, then high: RAMP_UP resumes.
